hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter: WIDTH, 32, data width of HI, LO and all data ports.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: wr_en  input  1  capture alu_lo/alu_hi into LO/HI (multu writeback).
REQ-005 Port: alu_lo  input  WIDTH  low product word from ALU.
REQ-006 Port: alu_hi  input  WIDTH  high product word from ALU.
REQ-007 Port: div_start  input  1  request unsigned division dividend/divisor.
REQ-008 Port: dividend  input  WIDTH  unsigned dividend, sampled with div_start.
REQ-009 Port: divisor  input  WIDTH  unsigned divisor, sampled with div_start.
REQ-010 Port: rd_sel  input  1  read select: 0 = LO, 1 = HI.
REQ-011 Port: rd_data  output  WIDTH  combinational mux of LO/HI registers per rd_sel.
REQ-012 Port: busy  output  1  division in progress; pipeline stall request.
REQ-013 Port: div_done  output  1  one-cycle pulse, division result committed.
REQ-014 Port: div_by_zero  output  1  one-cycle pulse with div_done when divisor was 0.

Function
REQ-015 FSM states SHALL be IDLE and DIV; IDLE -> DIV on div_start in IDLE; DIV -> IDLE after iteration counter reaches 0.
REQ-016 In IDLE, div_start SHALL latch dividend/divisor, clear partial remainder, load counter = WIDTH-1, enter DIV.
REQ-017 DIV SHALL perform one radix-2 restoring iteration per cycle: shift {rem, quo} left 1, subtract divisor from rem if rem >= divisor and set quotient LSB.
REQ-018 busy SHALL be 1 for exactly WIDTH cycles, starting the cycle after the div_start edge.
REQ-019 On the final iteration edge, LO SHALL get quotient, HI remainder, div_done pulse 1 for the following cycle, busy 0 in that same cycle.
REQ-020 Divisor 0 SHALL yield LO = all ones, HI = dividend, div_by_zero = 1 alongside div_done.
REQ-021 HI/LO SHALL remain unchanged during DIV; rd_data returns pre-division values while busy.
REQ-022 wr_en in IDLE without div_start SHALL load LO<=alu_lo, HI<=alu_hi at that edge; visible on rd_data next cycle.
REQ-023 Simultaneous wr_en and div_start in IDLE: div_start wins, wr_en ignored.
REQ-024 wr_en and div_start while busy SHALL be ignored (no queuing).
REQ-025 div_done and div_by_zero SHALL be 0 in every cycle except the completion cycle.

Reset
REQ-026 rst high at an edge SHALL set HI=0, LO=0, state IDLE, counter 0, busy=0, div_done=0, div_by_zero=0.
REQ-027 rst during DIV SHALL abort the division with no HI/LO commit and no div_done pulse.
REQ-028 rst SHALL take priority over wr_en and div_start in the same cycle.

Configuration
REQ-029 Macro HILO_DIV_EN defined: divider FSM and REQ-015..REQ-021, REQ-023, REQ-024 present.
REQ-030 HILO_DIV_EN undefined: no divider logic; div_start, dividend, divisor ignored; busy, div_done, div_by_zero tied 0; wr_en always honoured.

Verification
REQ-031 wr_en=1, alu_lo=0x00001234, alu_hi=0x0000ABCD -> next cycle rd_sel=0 gives 0x00001234, rd_sel=1 gives 0x0000ABCD.
REQ-032 div_start, 100/7 -> busy high 32 cycles, then div_done=1, LO=14, HI=2, div_by_zero=0.
REQ-033 div_start, 0x00000055/0 -> after 32 cycles LO=0xFFFFFFFF, HI=0x00000055, div_by_zero=1.
REQ-034 HI/LO preloaded 1/2, div_start 0xFFFFFFFF/1, rst at busy cycle 10 -> HI=LO=0, busy=0, no div_done.
REQ-035 wr_en and div_start same cycle (alu_lo=0x9, 20/3) -> LO=6, HI=2 after completion; wr_en during busy changes nothing.
REQ-036 HILO_DIV_EN undefined, div_start 100/7 -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/hilo_unit.sv
// HI/LO register pair with an optional 32-cycle radix-2 restoring unsigned divider.
// The divider is built only when the HILO_DIV_EN macro is defined. Without it, wr_en is always honoured and busy/div_done/div_by_zero are held at 0.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             div_done,
    output logic             div_by_zero
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    assign rd_data = rd_sel ? r_hi : r_lo;

`ifdef HILO_DIV_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_dvz;
    logic             r_done;
    logic             r_dbz;

    logic             w_start;
    logic             w_last;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (r_cnt == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    // A zero divisor needs no special case: every step subtracts 0, so the
    // quotient fills with ones and the remainder ends up as the dividend.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nxt = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_dvz   <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last;
            r_dbz   <= w_last & r_dvz;
            if (w_start) begin
                r_rem <= '0;
                r_quo <= dividend;
                r_dvs <= divisor;
                r_dvz <= (divisor == '0);
                r_cnt <= CW'(WIDTH - 1);
            end else if (r_state == S_DIV) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                if (w_last) begin
                    r_lo <= w_quo_nxt;
                    r_hi <= w_rem_nxt;
                end else begin
                    r_cnt <= r_cnt - CW'(1);
                end
            end else if (wr_en) begin
                r_lo <= alu_lo;
                r_hi <= alu_hi;
            end
        end
    end

    assign busy        = (r_state == S_DIV);
    assign div_done    = r_done;
    assign div_by_zero = r_dbz;
`else
    logic unused_div_in;
    assign unused_div_in = ^{div_start, dividend, divisor};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (wr_en) begin
            r_lo <= alu_lo;
            r_hi <= alu_hi;
        end
    end

    assign busy        = 1'b0;
    assign div_done    = 1'b0;
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Randomized self-checking bench for hilo_unit against a behavioural HI/LO model.
module tb_hilo_unit;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH-1:0] alu_hi;
    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             div_done;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;

    always #5 clk = ~clk;

    hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .alu_lo      (alu_lo),
        .alu_hi      (alu_hi),
        .div_start   (div_start),
        .dividend    (dividend),
        .divisor     (divisor),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .busy        (busy),
        .div_done    (div_done),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag);
        rd_sel = 1'b0;
        #1;
        check({tag, "_lo"}, rd_data, m_lo);
        rd_sel = 1'b1;
        #1;
        check({tag, "_hi"}, rd_data, m_hi);
    endtask

    task automatic do_wr(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
        wr_en  = 1'b1;
        alu_lo = lo;
        alu_hi = hi;
        tick();
        wr_en  = 1'b0;
        m_lo   = lo;
        m_hi   = hi;
    endtask

`ifdef HILO_DIV_EN
    task automatic run_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit with_wr, input bit noise);
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        int n;
        q = (b == 0) ? '1 : a / b;
        r = (b == 0) ? a : a % b;
        div_start = 1'b1;
        dividend  = a;
        divisor   = b;
        wr_en     = with_wr;
        alu_lo    = $urandom;
        alu_hi    = $urandom;
        tick();
        div_start = 1'b0;
        wr_en     = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            check("done_in_busy", div_done, 0);
            chk_regs("hold");
            if (noise) begin
                wr_en     = 1'($urandom_range(0, 1));
                div_start = 1'($urandom_range(0, 1));
                alu_lo    = $urandom;
                alu_hi    = $urandom;
                dividend  = $urandom;
                divisor   = $urandom;
            end
            n++;
            tick();
        end
        wr_en     = 1'b0;
        div_start = 1'b0;
        check("busy_cycles", n, WIDTH);
        check("div_done", div_done, 1);
        check("div_by_zero", div_by_zero, (b == 0));
        m_lo = q;
        m_hi = r;
        chk_regs("div");
        tick();
        check("done_pulse", div_done, 0);
        check("dbz_pulse", div_by_zero, 0);
        check("busy_after", busy, 0);
    endtask
`endif

    initial begin
        int seen;
        rst       = 1'b1;
        wr_en     = 1'b0;
        alu_lo    = '0;
        alu_hi    = '0;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        rd_sel    = 1'b0;
        m_lo      = '0;
        m_hi      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", div_done, 0);
        check("rst_dbz", div_by_zero, 0);
        chk_regs("rst");

        do_wr(32'h0000_1234, 32'h0000_ABCD);
        chk_regs("wr_basic");

        for (int i = 0; i < 20; i++) begin
            logic [WIDTH-1:0] lo;
            logic [WIDTH-1:0] hi;
            lo = $urandom;
            hi = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_wr(lo, hi);
            end else begin
                alu_lo = lo;
                alu_hi = hi;
                tick();
            end
            chk_regs("wr_rand");
        end

        rst       = 1'b1;
        wr_en     = 1'b1;
        div_start = 1'b1;
        alu_lo    = 32'hDEAD_BEEF;
        alu_hi    = 32'hCAFE_F00D;
        dividend  = 32'd100;
        divisor   = 32'd7;
        tick();
        rst       = 1'b0;
        wr_en     = 1'b0;
        div_start = 1'b0;
        m_lo      = '0;
        m_hi      = '0;
        check("rst_prio_busy", busy, 0);
        chk_regs("rst_prio");

`ifdef HILO_DIV_EN
        run_div(32'd100, 32'd7, 1'b0, 1'b0);
        run_div(32'h0000_0055, 32'd0, 1'b0, 1'b0);
        run_div(32'd20, 32'd3, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = WIDTH'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = a;
            endcase
            run_div(a, b, 1'($urandom_range(0, 1)), 1'b1);
        end

        do_wr(32'd2, 32'd1);
        div_start = 1'b1;
        dividend  = 32'hFFFF_FFFF;
        divisor   = 32'd1;
        tick();
        div_start = 1'b0;
        repeat (9) tick();
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        m_lo = '0;
        m_hi = '0;
        check("abort_busy", busy, 0);
        chk_regs("abort");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_done !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        check("abort_quiet", seen, 0);
        chk_regs("abort_end");
        do_wr(32'h0000_0077, 32'h0000_0088);
        chk_regs("post_abort_wr");
`else
        seen = 0;
        div_start = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy !== 1'b0 || div_done !== 1'b0 || div_by_zero !== 1'b0) seen++;
        end
        div_start = 1'b0;
        check("nodiv_quiet", seen, 0);
        chk_regs("nodiv_hold");
        div_start = 1'b1;
        do_wr(32'h0000_0009, 32'h0000_0003);
        div_start = 1'b0;
        chk_regs("nodiv_wr");
        check("nodiv_busy", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
